// File: rtl/axi_slv_rd_ctrl_pkg.sv
// Shared AXI widths, burst/resp encodings, FSM states and request record for the slave read responder.
// AXI_SLV_RD_WRAP_EN enables WRAP burst addressing; without it WRAP bursts answer SLVERR.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

package axi_slv_rd_ctrl_pkg;

    localparam int AW = `AXI_ADDR_WIDTH;
    localparam int DW = `AXI_DATA_WIDTH;
    localparam int IW = `AXI_ID_WIDTH;
    localparam int LW = `AXI_LEN_WIDTH;
    localparam int SW = `AXI_SIZE_WIDTH;
    localparam int BW = `AXI_BURST_WIDTH;
    localparam int RW = `AXI_RESP_WIDTH;

    localparam logic [BW-1:0] BURST_FIXED = 2'b00;
    localparam logic [BW-1:0] BURST_INCR  = 2'b01;
    localparam logic [BW-1:0] BURST_WRAP  = 2'b10;

    localparam logic [RW-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RW-1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [SW-1:0] size;
        logic [BW-1:0] burst;
    } rd_req_t;

`ifdef AXI_SLV_RD_WRAP_EN
    function automatic logic wrap_len_ok(input logic [LW-1:0] len);
        return len inside {LW'(1), LW'(3), LW'(7), LW'(15)};
    endfunction
`endif

endpackage

// File: rtl/axi_slv_rd_ctrl_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP boundary logic exists only when AXI_SLV_RD_WRAP_EN is defined.
import axi_slv_rd_ctrl_pkg::*;

module axi_burst_addr_gen (
    input  logic [`AXI_ADDR_WIDTH-1:0]  addr,
    input  logic [`AXI_SIZE_WIDTH-1:0]  size,
    input  logic [`AXI_LEN_WIDTH-1:0]   len,
    input  logic [`AXI_BURST_WIDTH-1:0] burst,
    output logic [`AXI_ADDR_WIDTH-1:0]  next_addr
);

    logic [AW-1:0] step;
    logic [AW-1:0] aligned;

    assign step    = AW'(1) << size;
    assign aligned = addr & ~(step - AW'(1));

`ifdef AXI_SLV_RD_WRAP_EN
    logic [AW-1:0] wrap_len;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] boundary;

    assign wrap_len  = (AW'(len) + AW'(1)) << size;
    assign wrap_mask = wrap_len - AW'(1);
    assign boundary  = addr & ~wrap_mask;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = aligned + step;
`ifdef AXI_SLV_RD_WRAP_EN
            BURST_WRAP: next_addr = boundary + ((addr + step) & wrap_mask);
`endif
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slv_rd_ctrl.sv
// AXI4 slave read responder: one AR at a time, one memory fetch per R beat.
// AXI_SLV_RD_WRAP_EN enables WRAP bursts (arlen 1/3/7/15); otherwise WRAP returns SLVERR.
import axi_slv_rd_ctrl_pkg::*;

// state    | meaning
// ST_IDLE  | arready high, waiting for an AR request
// ST_FETCH | one-cycle memory read strobe for the current beat
// ST_RESP  | R beat presented, held until rready
module axi_slv_rd_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         axi_slv_arvalid,
    output logic                         axi_slv_arready,
    input  logic [`AXI_ID_WIDTH-1:0]     axi_slv_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0]   axi_slv_araddr,
    input  logic [`AXI_LEN_WIDTH-1:0]    axi_slv_arlen,
    input  logic [`AXI_SIZE_WIDTH-1:0]   axi_slv_arsize,
    input  logic [`AXI_BURST_WIDTH-1:0]  axi_slv_arburst,
    input  logic [`AXI_LOCK_WIDTH-1:0]   axi_slv_arlock,
    input  logic [`AXI_CACHE_WIDTH-1:0]  axi_slv_arcache,
    input  logic [`AXI_PROT_WIDTH-1:0]   axi_slv_arprot,
    input  logic [`AXI_QOS_WIDTH-1:0]    axi_slv_arqos,
    input  logic [`AXI_REGION_WIDTH-1:0] axi_slv_arregion,
    output logic                         axi_slv_rvalid,
    input  logic                         axi_slv_rready,
    output logic [`AXI_ID_WIDTH-1:0]     axi_slv_rid,
    output logic [`AXI_DATA_WIDTH-1:0]   axi_slv_rdata,
    output logic [`AXI_RESP_WIDTH-1:0]   axi_slv_rresp,
    output logic                         axi_slv_rlast,
    output logic                         mem_rd_en,
    output logic [`AXI_ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [`AXI_DATA_WIDTH-1:0]   mem_rd_data,
    input  logic                         mem_rd_err
);

    logic [1:0]    state;
    rd_req_t       req_q;
    logic [LW:0]   beat_q;
    logic          bad_q;
    logic          first_q;
    logic [DW-1:0] hold_data_q;
    logic          hold_err_q;
    logic [AW-1:0] next_addr;
    logic          wrap_ok;
    logic          burst_ok;
    logic          ar_hs;
    logic          r_hs;
    logic          last_beat;
    logic          beat_err;
    logic          unused_ar;

    assign unused_ar = ^{axi_slv_arlock, axi_slv_arcache, axi_slv_arprot,
                         axi_slv_arqos, axi_slv_arregion};

`ifdef AXI_SLV_RD_WRAP_EN
    assign wrap_ok = wrap_len_ok(axi_slv_arlen);
`else
    assign wrap_ok = 1'b0;
`endif

    always_comb begin
        burst_ok = 1'b0;
        case (axi_slv_arburst)
            BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
            BURST_WRAP:              burst_ok = wrap_ok;
            default:                 burst_ok = 1'b0;
        endcase
    end

    axi_burst_addr_gen u_addr_gen (
        .addr      (req_q.addr),
        .size      (req_q.size),
        .len       (req_q.len),
        .burst     (req_q.burst),
        .next_addr (next_addr)
    );

    assign axi_slv_arready = (state == ST_IDLE);
    assign axi_slv_rvalid  = (state == ST_RESP);
    assign ar_hs           = axi_slv_arvalid && axi_slv_arready;
    assign r_hs            = axi_slv_rvalid && axi_slv_rready;
    assign last_beat       = (beat_q == {1'b0, req_q.len});

    // First RESP cycle forwards the memory port; later cycles replay the holding registers.
    assign beat_err      = first_q ? (bad_q || mem_rd_err) : hold_err_q;
    assign axi_slv_rdata = first_q ? (bad_q ? '0 : mem_rd_data) : hold_data_q;
    assign axi_slv_rresp = beat_err ? RESP_SLVERR : RESP_OKAY;
    assign axi_slv_rlast = axi_slv_rvalid && last_beat;
    assign axi_slv_rid   = req_q.id;

    assign mem_rd_en   = (state == ST_FETCH) && !bad_q;
    assign mem_rd_addr = req_q.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            beat_q      <= '0;
            bad_q       <= 1'b0;
            first_q     <= 1'b0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            first_q <= 1'b0;
            if (first_q) begin
                hold_data_q <= bad_q ? '0 : mem_rd_data;
                hold_err_q  <= bad_q || mem_rd_err;
            end
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        req_q.id    <= axi_slv_arid;
                        req_q.addr  <= axi_slv_araddr;
                        req_q.len   <= axi_slv_arlen;
                        req_q.size  <= axi_slv_arsize;
                        req_q.burst <= axi_slv_arburst;
                        beat_q      <= '0;
                        bad_q       <= !burst_ok;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    first_q <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (r_hs) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            req_q.addr <= next_addr;
                            beat_q     <= beat_q + 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slv_rd_ctrl.sv
// Scoreboard bench for axi_slv_rd_ctrl with directed bursts and a synchronous memory model.
// Expectations follow AXI_SLV_RD_WRAP_EN the same way the design does.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module tb_axi_slv_rd_ctrl;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          arvalid = 1'b0;
    logic                          arready;
    logic [`AXI_ID_WIDTH-1:0]      arid = '0;
    logic [`AXI_ADDR_WIDTH-1:0]    araddr = '0;
    logic [`AXI_LEN_WIDTH-1:0]     arlen = '0;
    logic [`AXI_SIZE_WIDTH-1:0]    arsize = '0;
    logic [`AXI_BURST_WIDTH-1:0]   arburst = '0;
    logic [`AXI_LOCK_WIDTH-1:0]    arlock = '0;
    logic [`AXI_CACHE_WIDTH-1:0]   arcache = '0;
    logic [`AXI_PROT_WIDTH-1:0]    arprot = '0;
    logic [`AXI_QOS_WIDTH-1:0]     arqos = '0;
    logic [`AXI_REGION_WIDTH-1:0]  arregion = '0;
    logic                          rvalid;
    logic                          rready = 1'b1;
    logic [`AXI_ID_WIDTH-1:0]      rid;
    logic [`AXI_DATA_WIDTH-1:0]    rdata;
    logic [`AXI_RESP_WIDTH-1:0]    rresp;
    logic                          rlast;
    logic                          mem_rd_en;
    logic [`AXI_ADDR_WIDTH-1:0]    mem_rd_addr;
    logic [`AXI_DATA_WIDTH-1:0]    mem_rd_data = '0;
    logic                          mem_rd_err = 1'b0;

    typedef struct {
        logic [`AXI_ID_WIDTH-1:0]   id;
        logic [`AXI_DATA_WIDTH-1:0] data;
        logic [`AXI_RESP_WIDTH-1:0] resp;
        logic                       last;
    } beat_t;

    beat_t                      exp_q[$];
    logic [`AXI_ADDR_WIDTH-1:0] addr_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int rd_pulses = 0;
    int beats_done = 0;
    int bp_beat = 0;
    int bp_left = 0;
    int mem_reads = 0;
    int err_at = -1;

    always #5 clk = ~clk;

    axi_slv_rd_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .axi_slv_arvalid  (arvalid),
        .axi_slv_arready  (arready),
        .axi_slv_arid     (arid),
        .axi_slv_araddr   (araddr),
        .axi_slv_arlen    (arlen),
        .axi_slv_arsize   (arsize),
        .axi_slv_arburst  (arburst),
        .axi_slv_arlock   (arlock),
        .axi_slv_arcache  (arcache),
        .axi_slv_arprot   (arprot),
        .axi_slv_arqos    (arqos),
        .axi_slv_arregion (arregion),
        .axi_slv_rvalid   (rvalid),
        .axi_slv_rready   (rready),
        .axi_slv_rid      (rid),
        .axi_slv_rdata    (rdata),
        .axi_slv_rresp    (rresp),
        .axi_slv_rlast    (rlast),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_err       (mem_rd_err)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous memory: data and error appear the cycle after the strobe and stay until the next read.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mdata(mem_rd_addr);
            mem_rd_err  <= (mem_reads == err_at);
            mem_reads   <= mem_reads + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_addr(input logic [31:0] a);
        addr_q.push_back(a);
    endtask

    task automatic push_beat(input logic [3:0] id, input logic [31:0] a, input logic err,
                             input logic last, input logic zero);
        beat_t b;
        b.id   = id;
        b.data = zero ? 32'h0 : mdata(a);
        b.resp = err ? 2'b10 : 2'b00;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic monitor();
        beat_t e;
        beat_t prev;
        logic [`AXI_ADDR_WIDTH-1:0] ea;
        logic prev_stall;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd_en) begin
                rd_pulses++;
                if (addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_addr: read at %0h, required no read", mem_rd_addr);
                end else begin
                    ea = addr_q.pop_front();
                    chk("mem_addr", 64'(mem_rd_addr), 64'(ea));
                end
            end
            if (prev_stall && rvalid) begin
                chk("hold_data", 64'(rdata), 64'(prev.data));
                chk("hold_last", 64'(rlast), 64'(prev.last));
                chk("hold_resp", 64'(rresp), 64'(prev.resp));
                chk("hold_id",   64'(rid),   64'(prev.id));
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL r_beat: beat data %0h, required no beat", rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rid",   64'(rid),   64'(e.id));
                    chk("rdata", 64'(rdata), 64'(e.data));
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'(e.last));
                end
                beats_done++;
            end
            prev_stall = rvalid && !rready;
            prev.id    = rid;
            prev.data  = rdata;
            prev.resp  = rresp;
            prev.last  = rlast;
        end
    endtask

    task automatic rready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (bp_left > 0 && rvalid && beats_done == bp_beat) begin
                rready = 1'b0;
                bp_left--;
            end else begin
                rready = 1'b1;
            end
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cnt;
        cnt = 0;
        beats_done = 0;
        rd_pulses = 0;
        arid = id;
        araddr = a;
        arlen = len;
        arsize = size;
        arburst = burst;
        arvalid = 1'b1;
        while (!arready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL ar_accept: arready %0d, required 1", arready);
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || !arready) && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: %0d beats outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        chk({nm, "_reads_left"}, 64'(addr_q.size()), 64'd0);
        addr_q.delete();
    endtask

    initial begin
        int cnt;
        fork
            monitor();
            rready_drv();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single beat with latency checks
        push_addr(32'h100);
        push_beat(4'd3, 32'h100, 1'b0, 1'b1, 1'b0);
        send_ar(4'd3, 32'h100, 8'd0, 3'd2, 2'b01);
        chk("t1_mem_rd_en", 64'(mem_rd_en), 64'd1);
        chk("t1_mem_rd_addr", 64'(mem_rd_addr), 64'h100);
        chk("t1_rvalid_early", 64'(rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("t2_rvalid", 64'(rvalid), 64'd1);
        chk("t2_rlast", 64'(rlast), 64'd1);
        chk("t2_rid", 64'(rid), 64'd3);
        chk("t2_rresp", 64'(rresp), 64'd0);
        chk("t2_arready", 64'(arready), 64'd0);
        @(posedge clk);
        #1;
        chk("t3_arready", 64'(arready), 64'd1);
        wait_done("single");

        // INCR from an unaligned start
        push_addr(32'h1002); push_addr(32'h1004); push_addr(32'h1008); push_addr(32'h100C);
        push_beat(4'd5, 32'h1002, 1'b0, 1'b0, 1'b0);
        push_beat(4'd5, 32'h1004, 1'b0, 1'b0, 1'b0);
        push_beat(4'd5, 32'h1008, 1'b0, 1'b0, 1'b0);
        push_beat(4'd5, 32'h100C, 1'b0, 1'b1, 1'b0);
        send_ar(4'd5, 32'h1002, 8'd3, 3'd2, 2'b01);
        wait_done("incr");
        chk("incr_reads", 64'(rd_pulses), 64'd4);

        // WRAP burst
`ifdef AXI_SLV_RD_WRAP_EN
        push_addr(32'h38); push_addr(32'h3C); push_addr(32'h30); push_addr(32'h34);
        push_beat(4'd6, 32'h38, 1'b0, 1'b0, 1'b0);
        push_beat(4'd6, 32'h3C, 1'b0, 1'b0, 1'b0);
        push_beat(4'd6, 32'h30, 1'b0, 1'b0, 1'b0);
        push_beat(4'd6, 32'h34, 1'b0, 1'b1, 1'b0);
        send_ar(4'd6, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_done("wrap");
        chk("wrap_reads", 64'(rd_pulses), 64'd4);
`else
        push_beat(4'd6, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd6, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd6, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd6, 32'h0, 1'b1, 1'b1, 1'b1);
        send_ar(4'd6, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_done("wrap");
        chk("wrap_reads", 64'(rd_pulses), 64'd0);
`endif

        // WRAP with an illegal length is an error either way
        push_beat(4'd4, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd4, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd4, 32'h0, 1'b1, 1'b1, 1'b1);
        send_ar(4'd4, 32'h40, 8'd2, 3'd2, 2'b10);
        wait_done("wrap_badlen");
        chk("wrap_badlen_reads", 64'(rd_pulses), 64'd0);

        // backpressure on beat 1
        push_addr(32'h400); push_addr(32'h404); push_addr(32'h408); push_addr(32'h40C);
        push_beat(4'd1, 32'h400, 1'b0, 1'b0, 1'b0);
        push_beat(4'd1, 32'h404, 1'b0, 1'b0, 1'b0);
        push_beat(4'd1, 32'h408, 1'b0, 1'b0, 1'b0);
        push_beat(4'd1, 32'h40C, 1'b0, 1'b1, 1'b0);
        bp_beat = 1;
        bp_left = 5;
        send_ar(4'd1, 32'h400, 8'd3, 3'd2, 2'b01);
        wait_done("bp");
        chk("bp_reads", 64'(rd_pulses), 64'd4);
        chk("bp_stall_used", 64'(bp_left), 64'd0);

        // memory error on beat 2
        err_at = mem_reads + 2;
        push_addr(32'h200); push_addr(32'h204); push_addr(32'h208); push_addr(32'h20C);
        push_beat(4'd2, 32'h200, 1'b0, 1'b0, 1'b0);
        push_beat(4'd2, 32'h204, 1'b0, 1'b0, 1'b0);
        push_beat(4'd2, 32'h208, 1'b1, 1'b0, 1'b0);
        push_beat(4'd2, 32'h20C, 1'b0, 1'b1, 1'b0);
        send_ar(4'd2, 32'h200, 8'd3, 3'd2, 2'b01);
        wait_done("memerr");
        err_at = -1;

        // reserved burst type
        push_beat(4'd7, 32'h0, 1'b1, 1'b0, 1'b1);
        push_beat(4'd7, 32'h0, 1'b1, 1'b1, 1'b1);
        send_ar(4'd7, 32'h500, 8'd1, 3'd2, 2'b11);
        wait_done("reserved");
        chk("reserved_reads", 64'(rd_pulses), 64'd0);

        // FIXED keeps the same address
        push_addr(32'h600); push_addr(32'h600); push_addr(32'h600);
        push_beat(4'd9, 32'h600, 1'b0, 1'b0, 1'b0);
        push_beat(4'd9, 32'h600, 1'b0, 1'b0, 1'b0);
        push_beat(4'd9, 32'h600, 1'b0, 1'b1, 1'b0);
        send_ar(4'd9, 32'h600, 8'd2, 3'd2, 2'b00);
        wait_done("fixed");

        // reset while beat 1 is stalled
        push_addr(32'h700); push_addr(32'h704);
        push_beat(4'd8, 32'h700, 1'b0, 1'b0, 1'b0);
        push_beat(4'd8, 32'h704, 1'b0, 1'b0, 1'b0);
        bp_beat = 1;
        bp_left = 1000;
        send_ar(4'd8, 32'h700, 8'd3, 3'd2, 2'b01);
        cnt = 0;
        while (!(beats_done == 1 && rvalid) && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("rstmid_reached_beat1", 64'(beats_done == 1 && rvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid", 64'(rvalid), 64'd0);
        chk("rstmid_arready", 64'(arready), 64'd1);
        chk("rstmid_rlast", 64'(rlast), 64'd0);
        chk("rstmid_rdata", 64'(rdata), 64'd0);
        chk("rstmid_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rstmid_reads_left", 64'(addr_q.size()), 64'd0);
        exp_q.delete();
        bp_left = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_addr(32'h710); push_addr(32'h714);
        push_beat(4'd10, 32'h710, 1'b0, 1'b0, 1'b0);
        push_beat(4'd10, 32'h714, 1'b0, 1'b1, 1'b0);
        send_ar(4'd10, 32'h710, 8'd1, 3'd2, 2'b01);
        wait_done("after_reset");
        chk("after_reset_reads", 64'(rd_pulses), 64'd2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_slv_rd_ctrl.md
# axi_slv_rd_ctrl

AXI4 slave-side read responder. Accepts one AR request at a time, walks the burst address sequence (FIXED/INCR/WRAP), fetches each beat from a synchronous memory port and returns it on the R channel with RID/RRESP/RLAST. It sits between an AXI interconnect slave port and an on-chip SRAM or register bank, and is the counterpart of the master read controller.

## Interface
- No parameters. All widths come from the shared `AXI_*_WIDTH` defines.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- axi_slv_arvalid  in  1  AR valid
- axi_slv_arready  out  1  AR ready
- axi_slv_arid / araddr / arlen / arsize / arburst  in  `AXI_ID/ADDR/LEN/SIZE/BURST_WIDTH`  AR payload
- axi_slv_arlock / arcache / arprot / arqos / arregion  in  respective widths  accepted, ignored
- axi_slv_rvalid  out  1  R valid
- axi_slv_rready  in  1  R ready
- axi_slv_rid  out  `AXI_ID_WIDTH`  echoed ARID
- axi_slv_rdata  out  `AXI_DATA_WIDTH`  beat data
- axi_slv_rresp  out  `AXI_RESP_WIDTH`  2'b00 OKAY, 2'b10 SLVERR
- axi_slv_rlast  out  1  final beat
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  `AXI_ADDR_WIDTH`  beat byte address
- mem_rd_data  in  `AXI_DATA_WIDTH`  valid the cycle after mem_rd_en
- mem_rd_err  in  1  error flag, same timing as mem_rd_data

## Operation
- FSM has three states: IDLE, FETCH, RESP.
- **IDLE:** arready=1. On arvalid&&arready, latch id, addr, len, size and burst. Clear beat counter. Go to FETCH.
- **FETCH:** mem_rd_en=1 for exactly one cycle, with mem_rd_addr = current beat address. Go to RESP.
- **RESP entry:** capture mem_rd_data and mem_rd_err into holding registers. Drive rvalid=1.
- **RESP hold:** rdata, rresp, rid and rlast are held stable while rvalid&&!rready.
- **RESP exit:** on rvalid&&rready, if rlast go to IDLE; otherwise advance the address, increment the beat counter and go to FETCH.
- rlast = (beat counter == latched arlen).
- rresp = SLVERR if the captured mem_rd_err=1, else OKAY.
- Beat counter width: `AXI_LEN_WIDTH`+1. It never wraps; a 256-beat burst ends at count 255.
- Address step is 1<<arsize bytes.
- **FIXED:** address is unchanged for every beat.
- **INCR:** beat 0 uses araddr as given. Later beats use the aligned address (araddr with the low arsize bits cleared) plus n·step.
- **WRAP:** wrap length = (arlen+1)·step. Boundary = araddr aligned down to the wrap length. Next address = boundary + ((addr+step) mod wrap length).
- Reserved burst type 2'b11: every beat returns SLVERR with rdata=0. mem_rd_en stays 0 in FETCH for this burst.
- No outstanding-transaction queue: arready stays 0 from acceptance until the last R handshake.

## Timing
- **Reset values:** arready=1, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_rd_en=0, mem_rd_addr=0. FSM starts in IDLE.
- **AR handshake at cycle T:** mem_rd_en at T+1; rvalid at T+2.
- **Throughput:** with rready held high, one beat every 2 cycles.
- **Back-to-back bursts:** last R handshake at cycle U gives arready=1 at U+1. The earliest next AR accept is at U+1.
- **Single beat (arlen=0):** rlast=1 on beat 0.
- **Reset mid-burst:** all outputs return to their reset values asynchronously. The burst in progress is dropped.
- **Backpressure:** rready low for any number of cycles is tolerated with no data loss and no repeated memory read.

## Configuration
- Macro: `AXI_SLV_RD_WRAP_EN`.
- **Defined:** WRAP bursts use the wrap addressing above. arlen must be 1, 3, 7 or 15; any other arlen with WRAP returns SLVERR on every beat with no memory reads.
- **Undefined:** WRAP is treated like the reserved type: SLVERR on every beat, no memory reads. The wrap-boundary logic is not compiled.

## Structure
- Shared package/defines hold: the AXI width macros, burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10), resp encodings (OKAY 2'b00, SLVERR 2'b10), and the FSM state encodings.
- One sub-module: `axi_burst_addr_gen`. It is combinational and computes the next address from (addr, size, len, burst).

## Test plan
- **Single beat:** ARADDR=0x100, arlen=0, arsize=2, INCR, id=3, rready=1 -> mem_rd_addr=0x100 at T+1; rvalid, rlast=1, rid=3, rresp=OKAY at T+2; arready=1 at T+3.
- **INCR burst:** ARADDR=0x1002, arlen=3, arsize=2, INCR -> mem_rd_addr sequence 0x1002, 0x1004, 0x1008, 0x100C; rlast only on beat 3.
- **WRAP burst (macro defined):** ARADDR=0x38, arlen=3, arsize=2 -> addresses 0x38, 0x3C, 0x30, 0x34. With the macro undefined -> 4 beats of SLVERR and mem_rd_en never asserted.
- **Backpressure:** 4-beat INCR with rready low for 5 cycles on beat 1 -> rdata/rlast stable throughout, exactly 4 mem_rd_en pulses, data order preserved.
- **Errors:** mem_rd_err=1 on beat 2 of 4 -> rresp SLVERR on beat 2 only. Burst type 2'b11 with arlen=1 -> 2 SLVERR beats, rdata=0.
- **Reset mid-burst:** assert rst_n=0 during beat 1 RESP -> rvalid=0 and arready=1 immediately. A new AR after release completes normally.
